// File: rtl/wrr_pop_scheduler_if.sv
// Handshake bundle between the WRR scheduler and its source/destination FIFOs.
// The master side drives the FIFO status, read data and enable; the slave side is the scheduler.
`timescale 1ns/1ps
interface wrr_pop_scheduler_if #(
    parameter int DATA_W = 12
);
    logic              enable;
    logic [3:0]        empty;
    logic [3:0]        almost_full;
    logic [DATA_W-1:0] data_in;
    logic [3:0]        pop;
    logic [3:0]        push;
    logic [DATA_W-1:0] data_out;
    logic [1:0]        sched_state;
    logic              idle;

    modport master (
        output enable, empty, almost_full, data_in,
        input  pop, push, data_out, sched_state, idle
    );

    modport slave (
        input  enable, empty, almost_full, data_in,
        output pop, push, data_out, sched_state, idle
    );
endinterface

// File: rtl/wrr_pop_scheduler.sv
// Weighted round-robin scheduler: pops up to one source VC FIFO per cycle, holds the grant
// for a burst weight, and routes each popped word two cycles later to its destination FIFO.
`timescale 1ns/1ps
module wrr_pop_scheduler #(
    parameter int         DATA_W   = 12,
    parameter int         DEST_LSB = 8,
    parameter logic [3:0] W0       = 4'd4,
    parameter logic [3:0] W1       = 4'd3,
    parameter logic [3:0] W2       = 4'd2,
    parameter logic [3:0] W3       = 4'd1
) (
    input  logic               clk,
    input  logic               reset_L,
    wrr_pop_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } state_t;

    function automatic logic [3:0] weight_of(input logic [1:0] idx);
        case (idx)
            2'd0:    weight_of = W0;
            2'd1:    weight_of = W1;
            2'd2:    weight_of = W2;
            default: weight_of = W3;
        endcase
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

    logic [1:0]        r_cur;
    logic [3:0]        r_credit;
    logic              r_rd_vld;
    logic [3:0]        r_push;
    logic [DATA_W-1:0] r_data_out;
    state_t            r_state;
    state_t            w_state_nxt;

    logic [1:0]        w_sel;
    logic              w_sel_vld;
    logic              w_reload;
    logic              w_pop_go;
    logic [3:0]        w_ne_rot;
    logic [1:0]        w_ofs;
    logic [1:0]        w_c1;
    logic [1:0]        w_c2;
    logic [1:0]        w_c3;

    // Source selection: stay on cur while it has data and credit, else rotate with reload.
    always_comb begin
        w_c1      = r_cur + 2'd1;
        w_c2      = r_cur + 2'd2;
        w_c3      = r_cur + 2'd3;
        w_ne_rot  = {!bus.empty[r_cur], !bus.empty[w_c3], !bus.empty[w_c2], !bus.empty[w_c1]};
        w_ofs     = 2'd0;
        w_sel     = r_cur;
        w_sel_vld = 1'b0;
        w_reload  = 1'b0;
        casez (w_ne_rot)
            4'b???1: w_ofs = 2'd1;
            4'b??10: w_ofs = 2'd2;
            4'b?100: w_ofs = 2'd3;
            4'b1000: w_ofs = 2'd0;
            default: w_ofs = 2'd0;
        endcase
        if (!bus.empty[r_cur] && (r_credit != 4'd0)) begin
            w_sel     = r_cur;
            w_sel_vld = 1'b1;
            w_reload  = 1'b0;
        end else begin
            w_sel     = r_cur + w_ofs;
            w_sel_vld = |w_ne_rot;
            w_reload  = |w_ne_rot;
        end
    end

    // Pops are gated by reset so nothing is read from a source while the block is held in reset.
    assign w_pop_go = w_sel_vld && bus.enable && (bus.almost_full == 4'b0000) && reset_L;
    assign bus.pop  = w_pop_go ? onehot4(w_sel) : 4'b0000;

    // Grant pointer and burst credit; both hold whenever no pop is issued.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_cur    <= 2'd0;
            r_credit <= W0;
        end else if (w_pop_go) begin
            if (w_reload) begin
                r_cur    <= w_sel;
                r_credit <= weight_of(w_sel) - 4'd1;
            end else begin
                r_credit <= r_credit - 4'd1;
            end
        end
    end

    // Read-valid marks the cycle in which data_in carries the word popped last cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_pop_go;
        end
    end

    // Capture the read word and strobe its destination FIFO for exactly one cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_push     <= 4'b0000;
            r_data_out <= {DATA_W{1'b0}};
        end else if (r_rd_vld) begin
            r_push     <= onehot4(bus.data_in[DEST_LSB+1:DEST_LSB]);
            r_data_out <= bus.data_in;
        end else begin
            r_push     <= 4'b0000;
        end
    end

    // Scheduler state register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state by priority: disabled, then backpressure, then pending data.
    always_comb begin
        w_state_nxt = ST_IDLE;
        if (!bus.enable) begin
            w_state_nxt = ST_IDLE;
        end else if (|bus.almost_full) begin
            w_state_nxt = ST_STALL;
        end else if (!(&bus.empty)) begin
            w_state_nxt = ST_ACTIVE;
        end else begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign bus.push        = r_push;
    assign bus.data_out    = r_data_out;
    assign bus.sched_state = r_state;
    assign bus.idle        = (&bus.empty) && !r_rd_vld && (r_push == 4'b0000);
endmodule

// File: tb/tb_wrr_pop_scheduler.sv
// Bench for wrr_pop_scheduler: behavioural source FIFOs feed the DUT and every observed pop
// queues the word expected on the destination side two cycles later.
`timescale 1ns/1ps
module tb_wrr_pop_scheduler;
    localparam int DATA_W = 12;

    typedef struct {
        int          due;
        logic [11:0] word;
    } exp_t;

    logic clk = 1'b0;
    logic reset_L;
    always #5 clk = ~clk;

    wrr_pop_scheduler_if #(.DATA_W(DATA_W)) bus();

    wrr_pop_scheduler #(
        .DATA_W(DATA_W), .DEST_LSB(8),
        .W0(4'd4), .W1(4'd3), .W2(4'd2), .W3(4'd1)
    ) dut (
        .clk(clk),
        .reset_L(reset_L),
        .bus(bus)
    );

    logic [11:0] srcq [4][$];
    exp_t        sb[$];
    int          pop_log[$];
    int          pop_cyc[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          seqn    = 0;
    bit          pend_vld = 1'b0;
    int          pend_src = 0;
    exp_t        m_e;
    int          m_src;
    logic [3:0]  m_exp_push;

    task automatic upd_empty();
        for (int i = 0; i < 4; i++) bus.empty[i] = (srcq[i].size() == 0);
    endtask

    task automatic load(input int src, input int n);
        for (int i = 0; i < n; i++) begin
            srcq[src].push_back({2'(src), 2'($urandom_range(0, 3)), 8'(seqn)});
            seqn++;
        end
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < 4; i++) srcq[i].delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Source FIFO model: a pop seen in cycle T presents its word on data_in during T+1.
    always @(posedge clk) begin
        #1;
        if (pend_vld) begin
            bus.data_in = srcq[pend_src].pop_front();
            pend_vld = 1'b0;
        end
        upd_empty();
    end

    // Destination monitor and scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (!reset_L) begin
            sb.delete();
        end else begin
            if (bus.push != 4'b0000) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_push push=%b data_out=%h (no word pending)", bus.push, bus.data_out);
                end else begin
                    m_e = sb.pop_front();
                    m_exp_push = 4'b0001 << m_e.word[9:8];
                    if (bus.push !== m_exp_push || bus.data_out !== m_e.word || m_e.due != cyc) begin
                        n_fail++;
                        $display("FAIL sb_push got push=%b data=%h cyc=%0d expected push=%b data=%h cyc=%0d",
                                 bus.push, bus.data_out, cyc, m_exp_push, m_e.word, m_e.due);
                    end
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_missing_push push=0000 expected data=%h at cyc=%0d", sb[0].word, sb[0].due);
                void'(sb.pop_front());
            end
            if (bus.pop != 4'b0000) begin
                n_tests++;
                m_src = (bus.pop[1] ? 1 : 0) + (bus.pop[2] ? 2 : 0) + (bus.pop[3] ? 3 : 0);
                if ($countones(bus.pop) != 1 || srcq[m_src].size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_legal pop=%b empty=%b required one-hot pop of a non-empty source", bus.pop, bus.empty);
                end else begin
                    pop_log.push_back(m_src);
                    pop_cyc.push_back(cyc);
                    m_e.due  = cyc + 2;
                    m_e.word = srcq[m_src][0];
                    sb.push_back(m_e);
                    pend_vld = 1'b1;
                    pend_src = m_src;
                end
            end
        end
    end

    task automatic do_reset();
        tick();
        reset_L = 1'b0;
        tick();
        tick();
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        bus.enable = 1'b0;
        bus.almost_full = 4'b0000;
        bus.data_in = 12'h000;
        upd_empty();
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.enable      = 1'($urandom_range(0, 1));
            bus.almost_full = 4'($urandom_range(0, 15));
            bus.data_in     = 12'($urandom);
            clear_srcs();
            for (int s = 0; s < 4; s++) load(s, $urandom_range(0, 1));
            upd_empty();
            @(negedge clk);
            n_tests++;
            if (bus.pop !== 4'b0 || bus.push !== 4'b0 || bus.data_out !== 12'h000 || bus.sched_state !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_outputs pop=%b push=%b data_out=%h state=%0d required all zero",
                         bus.pop, bus.push, bus.data_out, bus.sched_state);
            end
            n_tests++;
            if (bus.idle !== (&bus.empty)) begin
                n_fail++;
                $display("FAIL reset_idle idle=%b required %b (empty=%b)", bus.idle, &bus.empty, bus.empty);
            end
        end
        tick();
        clear_srcs();
        upd_empty();
        bus.enable = 1'b1;
        bus.almost_full = 4'b0000;
        reset_L = 1'b1;
    endtask

    task automatic test_wrr();
        int pat[10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
        pop_log.delete();
        pop_cyc.delete();
        tick();
        for (int s = 0; s < 4; s++) load(s, 20);
        upd_empty();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pop_log.size() >= 80) break;
        end
        n_tests++;
        if (pop_log.size() != 80) begin
            n_fail++;
            $display("FAIL wrr_drain pops=%0d required 80", pop_log.size());
        end
        for (int k = 0; k < 40; k++) begin
            n_tests++;
            if (k >= pop_log.size() || pop_log[k] != pat[k % 10]) begin
                n_fail++;
                $display("FAIL wrr_order idx=%0d got src=%0d required src=%0d", k,
                         (k < pop_log.size()) ? pop_log[k] : -1, pat[k % 10]);
            end else if (k > 0 && pop_cyc[k] != pop_cyc[k-1] + 1) begin
                n_fail++;
                $display("FAIL wrr_rate idx=%0d got gap=%0d required 1", k, pop_cyc[k] - pop_cyc[k-1]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_routing();
        tick();
        srcq[1].push_back(12'h2A5);
        upd_empty();
        @(negedge clk);
        n_tests++;
        if (bus.pop !== 4'b0010) begin
            n_fail++; $display("FAIL route_pop pop=%b required 0010", bus.pop);
        end
        @(negedge clk);
        n_tests++;
        if (bus.push !== 4'b0000) begin
            n_fail++; $display("FAIL route_early push=%b required 0000", bus.push);
        end
        @(negedge clk);
        n_tests++;
        if (bus.push !== 4'b0100 || bus.data_out !== 12'h2A5) begin
            n_fail++; $display("FAIL route_push push=%b data_out=%h required 0100/2a5", bus.push, bus.data_out);
        end
        @(negedge clk);
        n_tests++;
        if (bus.push !== 4'b0000) begin
            n_fail++; $display("FAIL route_single push=%b required 0000", bus.push);
        end
    endtask

    task automatic test_skip_reload();
        tick();
        load(2, 5);
        upd_empty();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.pop !== 4'b0100) begin
                n_fail++; $display("FAIL skip_pop idx=%0d pop=%b required 0100", i, bus.pop);
            end
        end
        @(negedge clk);
        n_tests++;
        if (bus.pop !== 4'b0000 || bus.idle !== 1'b0) begin
            n_fail++; $display("FAIL skip_after pop=%b idle=%b required 0000/0", bus.pop, bus.idle);
        end
        @(negedge clk);
        n_tests++;
        if (bus.idle !== 1'b0) begin
            n_fail++; $display("FAIL skip_idle_push idle=%b required 0 while last push active", bus.idle);
        end
        @(negedge clk);
        n_tests++;
        if (bus.idle !== 1'b1) begin
            n_fail++; $display("FAIL skip_idle idle=%b required 1", bus.idle);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        tick();
        load(0, 8);
        load(1, 8);
        upd_empty();
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if (bus.pop !== 4'b0001) begin
                n_fail++; $display("FAIL bp_pre pop=%b required 0001", bus.pop);
            end
        end
        tick();
        bus.almost_full = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.pop !== 4'b0000 || ((i < 2) != (bus.push != 4'b0000))) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d pop=%b push=%b required pop 0000, push only in first two", i, bus.pop, bus.push);
            end
            if (i > 0) begin
                n_tests++;
                if (bus.sched_state !== 2'd2) begin
                    n_fail++; $display("FAIL bp_state state=%0d required 2", bus.sched_state);
                end
            end
        end
        tick();
        bus.almost_full = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.pop !== ((i < 2) ? 4'b0001 : 4'b0010)) begin
                n_fail++; $display("FAIL bp_resume idx=%0d pop=%b required %b", i, bus.pop, (i < 2) ? 4'b0001 : 4'b0010);
            end
        end
    endtask

    task automatic test_async_reset();
        tick();
        reset_L = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.push !== 4'b0000 || bus.pop !== 4'b0000) begin
            n_fail++; $display("FAIL ar_drop push=%b pop=%b required 0000/0000", bus.push, bus.pop);
        end
        tick();
        load(0, 5);
        load(1, 2);
        upd_empty();
        @(negedge clk);
        n_tests++;
        if (bus.push !== 4'b0000) begin
            n_fail++; $display("FAIL ar_nopush push=%b required 0000", bus.push);
        end
        tick();
        reset_L = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.pop !== ((i < 4) ? 4'b0001 : 4'b0010)) begin
                n_fail++; $display("FAIL ar_restart idx=%0d pop=%b required %b", i, bus.pop, (i < 4) ? 4'b0001 : 4'b0010);
            end
        end
        tick();
        clear_srcs();
        upd_empty();
        repeat (4) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover pending=%0d required 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wrr();
        test_routing();
        test_skip_reload();
        test_backpressure();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
